// File: rtl/ammo_loader_pkg.sv
// Shared definitions for the ammo loader: FSM encodings, default
// parameter values and the width helper used for compare/subtract math.
package ammo_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_N     = 9;
  localparam int DEF_RW    = 12;
  localparam int DEF_CAP   = 500;
  localparam int DEF_BATCH = 25;

  // Width wide enough to add/subtract an N-bit and an RW-bit quantity
  // without wrapping: one bit above the wider operand.
  function automatic int calc_w(input int a, input int b);
    return ((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/ammo_step_calc.sv
// Per-cycle transfer size: min(BATCH, CAP - acc, reserve).
// Purely combinational so it can be exercised on its own.
module ammo_step_calc
  import ammo_loader_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int RW    = DEF_RW,
  parameter int CAP   = DEF_CAP,
  parameter int BATCH = DEF_BATCH,
  parameter int W     = calc_w(DEF_N, DEF_RW)
) (
  input  logic [N-1:0]  acc,
  input  logic [RW-1:0] reserve,
  output logic [W-1:0]  step
);

  logic [W-1:0] acc_w;
  logic [W-1:0] res_w;
  logic [W-1:0] room;
  logic [W-1:0] min_a;

  // Three-way minimum; room clamps at zero so a full magazine never
  // produces a wrapped difference.
  always_comb begin
    acc_w = W'(acc);
    res_w = W'(reserve);
    room  = (acc_w >= W'(CAP)) ? '0 : (W'(CAP) - acc_w);
    min_a = (W'(BATCH) < room) ? W'(BATCH) : room;
    step  = (min_a < res_w) ? min_a : res_w;
  end

endmodule

// File: rtl/ammo_loader.sv
// Reserve-stock feeder that streams rounds into the weapon magazine.
// Optional build macro: AMMO_LOADER_AUDIT_EN adds the 16-bit saturating
// delivered_total lifetime counter output.
module ammo_loader
  import ammo_loader_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int RW    = DEF_RW,
  parameter int CAP   = DEF_CAP,
  parameter int BATCH = DEF_BATCH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          depot_valid,
  input  logic [RW-1:0] depot_rounds,
  output logic          depot_ready,
  input  logic          reload_req,
  input  logic          abort,
  input  logic [N-1:0]  cur_ammo,
  output logic [N-1:0]  ammo_out,
  output logic          load_out,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] reserve,
  output logic          empty
`ifdef AMMO_LOADER_AUDIT_EN
  ,
  output logic [15:0]   delivered_total
`endif
);

  localparam int W = calc_w(N, RW);
  localparam logic [RW-1:0] RES_MAX = '1;

  state_t        state_reg, state_next;
  logic [N-1:0]  acc_reg, acc_next;
  logic [RW-1:0] reserve_reg, reserve_next;
  logic [W-1:0]  step;
  logic [W-1:0]  acc_after;
  logic [W-1:0]  res_after;
  logic [RW:0]   depot_sum;
  logic          depot_fire;
  logic          load_step;

  ammo_step_calc #(
    .N(N), .RW(RW), .CAP(CAP), .BATCH(BATCH), .W(W)
  ) u_step (
    .acc     (acc_reg),
    .reserve (reserve_reg),
    .step    (step)
  );

  assign depot_ready = (state_reg == IDLE) & ~rst;
  assign depot_fire  = depot_valid & depot_ready;
  assign depot_sum   = {1'b0, reserve_reg} + {1'b0, depot_rounds};
  assign acc_after   = W'(acc_reg) + step;
  assign res_after   = W'(reserve_reg) - step;

  // Next-state, accumulator and reserve update. The reload decision in
  // IDLE looks at the pre-add reserve; a same-cycle depot add lands in
  // the register and is therefore visible to the first LOAD step.
  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    reserve_next = reserve_reg;
    load_step    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (depot_fire)
          reserve_next = depot_sum[RW] ? RES_MAX : depot_sum[RW-1:0];
        if (reload_req && (reserve_reg != '0) && (W'(cur_ammo) < W'(CAP))) begin
          state_next = LOAD;
          acc_next   = cur_ammo;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = DONE;
        end else begin
          load_step    = 1'b1;
          acc_next     = acc_after[N-1:0];
          reserve_next = res_after[RW-1:0];
          if ((acc_after == W'(CAP)) || (res_after == '0))
            state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, accumulator and reserve registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      reserve_reg <= '0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      reserve_reg <= reserve_next;
    end
  end

  // During a stepping LOAD cycle the weapon is handed the post-step count,
  // so the last LOAD cycle presents the final magazine value.
  assign ammo_out = load_step ? acc_after[N-1:0] : acc_reg;
  assign load_out = (state_reg == LOAD);
  assign busy     = (state_reg == LOAD);
  assign done     = (state_reg == DONE);
  assign reserve  = reserve_reg;
  assign empty    = (reserve_reg == '0);

`ifdef AMMO_LOADER_AUDIT_EN
  logic [15:0] delivered_reg;
  logic [16:0] delivered_sum;

  assign delivered_sum = {1'b0, delivered_reg} + 17'(step);

  // Lifetime delivered-rounds counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      delivered_reg <= '0;
    else if (load_step)
      delivered_reg <= delivered_sum[16] ? 16'hFFFF : delivered_sum[15:0];
  end

  assign delivered_total = delivered_reg;
`endif

endmodule

// File: tb/tb_ammo_loader.sv
// Scoreboard bench for ammo_loader: stimulus pushes the expected LOAD/DONE
// cycles, a negedge monitor pops and compares whenever the DUT is busy or done.
module tb_ammo_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        depot_valid;
  logic [11:0] depot_rounds;
  logic        depot_ready;
  logic        reload_req;
  logic        abort;
  logic [8:0]  cur_ammo;
  logic [8:0]  ammo_out;
  logic        load_out;
  logic        busy;
  logic        done;
  logic [11:0] reserve;
  logic        empty;
`ifdef AMMO_LOADER_AUDIT_EN
  logic [15:0] delivered_total;
`endif

  ammo_loader dut (
    .clk          (clk),
    .rst          (rst),
    .depot_valid  (depot_valid),
    .depot_rounds (depot_rounds),
    .depot_ready  (depot_ready),
    .reload_req   (reload_req),
    .abort        (abort),
    .cur_ammo     (cur_ammo),
    .ammo_out     (ammo_out),
    .load_out     (load_out),
    .busy         (busy),
    .done         (done),
    .reserve      (reserve),
    .empty        (empty)
`ifdef AMMO_LOADER_AUDIT_EN
    ,
    .delivered_total (delivered_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_done;
    logic [8:0]  ammo;
    logic [11:0] res;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic d, input int a, input int r);
    exp_t e;
    e.is_done = d;
    e.ammo    = 9'(a);
    e.res     = 12'(r);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one line per observed LOAD/DONE cycle.
  always @(negedge clk) begin
    if (load_out === 1'b1 || done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: load_out=%0b done=%0b ammo_out=%0d with no expectation queued",
                 load_out, done, ammo_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn %s ammo_out=%0d reserve=%0d (exp %0d/%0d)",
                 e.is_done ? "DONE" : "LOAD", ammo_out, reserve, e.ammo, e.res);
        chk("mon_load_out", 16'(load_out), 16'(!e.is_done));
        chk("mon_busy",     16'(busy),     16'(!e.is_done));
        chk("mon_done",     16'(done),     16'(e.is_done));
        chk("mon_ammo_out", 16'(ammo_out), 16'(e.ammo));
        chk("mon_reserve",  16'(reserve),  16'(e.res));
      end
    end
  end

  task automatic depot(input int v);
    depot_valid  = 1'b1;
    depot_rounds = 12'(v);
    tick();
    depot_valid  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget && done !== 1'b1; i++) tick();
    chk({name, "_done_seen"}, 16'(done), 16'd1);
    tick();
    chk({name, "_back_idle"}, 16'(load_out | done), 16'd0);
    chk({name, "_sb_drained"}, 16'(sb_q.size()), 16'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_ignored(input string name);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(name, 16'(load_out), 16'd0);
    end
    reload_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; depot_valid = 1'b0; depot_rounds = '0;
    reload_req = 1'b0; abort = 1'b0; cur_ammo = '0;

    // Reset values, sampled while rst is still high.
    tick();
    chk("rst_ammo_out",    16'(ammo_out),    16'd0);
    chk("rst_load_out",    16'(load_out),    16'd0);
    chk("rst_busy",        16'(busy),        16'd0);
    chk("rst_done",        16'(done),        16'd0);
    chk("rst_empty",       16'(empty),       16'd1);
    chk("rst_reserve",     16'(reserve),     16'd0);
    chk("rst_depot_ready", 16'(depot_ready), 16'd0);
    rst = 1'b0;
    tick();
    chk("idle_depot_ready", 16'(depot_ready), 16'd1);

    // Fill and full reload: 12 LOAD cycles, stop on reserve exhaustion.
    depot(300);
    chk("fill_reserve", 16'(reserve), 16'd300);
    for (int k = 1; k <= 12; k++) push_exp(1'b0, 25 * k, 300 - 25 * (k - 1));
    push_exp(1'b1, 300, 0);
    reload_req = 1'b1; cur_ammo = 9'd0;
    tick();
    reload_req = 1'b0;
    wait_done(30, "full");
    chk("full_empty", 16'(empty), 16'd1);

    // Reload with empty reserve is ignored.
    reload_req = 1'b1;
    check_ignored("ign_res0_load_out");

    // Same-cycle depot and reload: decision uses the pre-add reserve (0).
    depot_valid = 1'b1; depot_rounds = 12'd100; reload_req = 1'b1;
    tick();
    depot_valid = 1'b0; reload_req = 1'b0;
    chk("sim0_load_out", 16'(load_out), 16'd0);
    chk("sim0_reserve",  16'(reserve),  16'd100);
    // Same-cycle again, now accepted; first step sees post-add reserve 150.
    for (int k = 1; k <= 6; k++) push_exp(1'b0, 25 * k, 150 - 25 * (k - 1));
    push_exp(1'b1, 150, 0);
    depot_valid = 1'b1; depot_rounds = 12'd50; reload_req = 1'b1;
    tick();
    depot_valid = 1'b0; reload_req = 1'b0;
    wait_done(20, "sim");

    // Capacity-limited partial step.
    depot(1000);
    chk("cap_reserve_in", 16'(reserve), 16'd1000);
    push_exp(1'b0, 500, 1000);
    push_exp(1'b1, 500, 980);
    reload_req = 1'b1; cur_ammo = 9'd480;
    tick();
    reload_req = 1'b0;
    wait_done(10, "cap");
    chk("cap_reserve_out", 16'(reserve), 16'd980);

    // Abort in the 3rd LOAD cycle.
    do_reset();
    depot(500);
    push_exp(1'b0, 25, 500);
    push_exp(1'b0, 50, 475);
    push_exp(1'b0, 50, 450);
    push_exp(1'b1, 50, 450);
    reload_req = 1'b1; cur_ammo = 9'd0;
    tick();
    reload_req = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(5, "abort");
    chk("abort_ammo_held", 16'(ammo_out), 16'd50);
    chk("abort_reserve",   16'(reserve),  16'd450);

    // Depot saturation.
    do_reset();
    depot(4000);
    chk("sat_first",  16'(reserve), 16'd4000);
    depot(4000);
    chk("sat_second", 16'(reserve), 16'd4095);

    // Depot blocked during LOAD.
    for (int k = 1; k <= 20; k++) push_exp(1'b0, 25 * k, 4095 - 25 * (k - 1));
    push_exp(1'b1, 500, 3595);
    reload_req = 1'b1; cur_ammo = 9'd0;
    tick();
    reload_req = 1'b0;
    depot_valid = 1'b1; depot_rounds = 12'd100;
    chk("blk_depot_ready", 16'(depot_ready), 16'd0);
    tick();
    tick();
    depot_valid = 1'b0;
    wait_done(40, "blk");
    chk("blk_reserve", 16'(reserve), 16'd3595);

    // Reload with a full magazine is ignored.
    reload_req = 1'b1; cur_ammo = 9'd500;
    check_ignored("ign_full_load_out");

    // Reset in the 2nd LOAD cycle.
    push_exp(1'b0, 25, 3595);
    push_exp(1'b0, 50, 3570);
    reload_req = 1'b1; cur_ammo = 9'd0;
    tick();
    reload_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_ammo_out",    16'(ammo_out),    16'd0);
    chk("mrst_load_out",    16'(load_out),    16'd0);
    chk("mrst_busy",        16'(busy),        16'd0);
    chk("mrst_done",        16'(done),        16'd0);
    chk("mrst_empty",       16'(empty),       16'd1);
    chk("mrst_reserve",     16'(reserve),     16'd0);
    chk("mrst_depot_ready", 16'(depot_ready), 16'd0);
    rst = 1'b0;
    tick();
    chk("mrst_idle_ready", 16'(depot_ready), 16'd1);
    chk("final_sb_empty",  16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
